// File: rtl/fast_frame_serializer_if.sv
// Byte-stream bundle between the encode pipeline, fast_frame_serializer and the transmit path.
// The serializer takes the slave modport; the producer/consumer side takes master.
interface fast_frame_serializer_if #(
   parameter int CH_NUM    = 3,
   parameter int MSG_BYTES = 33,
   parameter int LEN_BITS  = 6
);
   logic                            message_en_in;
   logic [CH_NUM*MSG_BYTES*8-1:0]   message_fast_in;
   logic [CH_NUM*LEN_BITS-1:0]      length_fast_in;
   logic                            byte_ready_in;
   logic [7:0]                      byte_out;
   logic                            byte_valid_out;
   logic                            sof_out;
   logic                            eof_out;
   logic                            busy_out;
   logic                            len_err_out;
   logic [15:0]                     drop_cnt_out;

   modport slave (
      input  message_en_in, message_fast_in, length_fast_in, byte_ready_in,
      output byte_out, byte_valid_out, sof_out, eof_out, busy_out, len_err_out, drop_cnt_out
   );

   modport master (
      output message_en_in, message_fast_in, length_fast_in, byte_ready_in,
      input  byte_out, byte_valid_out, sof_out, eof_out, busy_out, len_err_out, drop_cnt_out
   );
endinterface

// File: rtl/fast_frame_serializer.sv
// Serialises one captured multi-channel FAST packet into HEAD, (LEN, BODY...)*, [CSUM], ETX bytes.
// Optional checksum byte enabled by defining FAST_CHECKSUM_EN.
module fast_frame_serializer #(
   parameter int          CH_NUM    = 3,
   parameter int          MSG_BYTES = 33,
   parameter int          LEN_BITS  = 6,
   parameter logic [7:0]  HEAD_BYTE = 8'h02,
   parameter logic [7:0]  ETX_BYTE  = 8'h03
) (
   input logic                   clk,
   input logic                   rst,
   fast_frame_serializer_if.slave bus
);
   localparam int                  CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam logic [LEN_BITS-1:0] MSG_MAX = LEN_BITS'(MSG_BYTES);

   typedef enum logic [2:0] {
      IDLE,
      HEAD,
      LEN,
      BODY,
`ifdef FAST_CHECKSUM_EN
      CSUM,
`endif
      ETX
   } state_t;

   state_t               state_reg, state_next;
   logic [CH_W-1:0]      ch_reg, ch_next;
   logic [LEN_BITS-1:0]  idx_reg, idx_next;
   logic                 len_err_reg;
   logic [15:0]          drop_cnt_reg;

   logic [7:0]           msg_reg [CH_NUM][MSG_BYTES];
   logic [LEN_BITS-1:0]  len_reg [CH_NUM];

   logic [7:0]           raw_msg   [CH_NUM][MSG_BYTES];
   logic [LEN_BITS-1:0]  clamp_len [CH_NUM];
   logic [CH_NUM-1:0]    over_len;

   logic                 capture;
   logic                 hs;
   logic [7:0]           byte_mux;
   logic                 first_found, next_found;
   logic [CH_W-1:0]      first_ch, next_ch;

`ifdef FAST_CHECKSUM_EN
   logic [7:0]           csum_reg, csum_next;
`endif

   // Slice the flat input buses; byte 0 of a channel is the most significant byte of its slice.
   genvar gi, gj;
   generate
      for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
         logic [LEN_BITS-1:0] raw_len;
         assign raw_len       = bus.length_fast_in[gi*LEN_BITS +: LEN_BITS];
         assign over_len[gi]  = (raw_len > MSG_MAX);
         assign clamp_len[gi] = over_len[gi] ? MSG_MAX : raw_len;
         for (gj = 0; gj < MSG_BYTES; gj++) begin : g_byte
            assign raw_msg[gi][gj] = bus.message_fast_in[gi*MSG_BYTES*8 + (MSG_BYTES-1-gj)*8 +: 8];
         end
      end
   endgenerate

   assign capture = (state_reg == IDLE) && bus.message_en_in;
   assign hs      = (state_reg != IDLE) && bus.byte_ready_in;

   // Lowest nonzero channel overall, and lowest nonzero channel above the current one.
   always_comb begin
      first_found = 1'b0;
      first_ch    = '0;
      next_found  = 1'b0;
      next_ch     = '0;
      for (int i = CH_NUM-1; i >= 0; i--) begin
         if (len_reg[i] != '0) begin
            first_found = 1'b1;
            first_ch    = CH_W'(i);
            if (CH_W'(i) > ch_reg) begin
               next_found = 1'b1;
               next_ch    = CH_W'(i);
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ch_next    = ch_reg;
      idx_next   = idx_reg;
      byte_mux   = 8'h00;
      case (state_reg)
         IDLE: begin
            if (bus.message_en_in) begin
               state_next = HEAD;
               ch_next    = '0;
            end
         end
         HEAD: begin
            byte_mux = HEAD_BYTE;
            if (hs) begin
               if (first_found) begin
                  ch_next    = first_ch;
                  state_next = LEN;
               end else begin
`ifdef FAST_CHECKSUM_EN
                  state_next = CSUM;
`else
                  state_next = ETX;
`endif
               end
            end
         end
         LEN: begin
            byte_mux = 8'(len_reg[ch_reg]);
            if (hs) begin
               state_next = BODY;
               idx_next   = '0;
            end
         end
         BODY: begin
            byte_mux = msg_reg[ch_reg][idx_reg];
            if (hs) begin
               // Clamped length never reaches 2^LEN_BITS, so idx+1 cannot wrap.
               if ((idx_reg + LEN_BITS'(1)) == len_reg[ch_reg]) begin
                  if (next_found) begin
                     ch_next    = next_ch;
                     state_next = LEN;
                  end else begin
`ifdef FAST_CHECKSUM_EN
                     state_next = CSUM;
`else
                     state_next = ETX;
`endif
                  end
               end else begin
                  idx_next = idx_reg + LEN_BITS'(1);
               end
            end
         end
`ifdef FAST_CHECKSUM_EN
         CSUM: begin
            byte_mux = csum_reg;
            if (hs) state_next = ETX;
         end
`endif
         ETX: begin
            byte_mux = ETX_BYTE;
            if (hs) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef FAST_CHECKSUM_EN
   always_comb begin
      csum_next = csum_reg;
      if (capture) begin
         csum_next = 8'h00;
      end else if (hs && (state_reg == LEN || state_reg == BODY)) begin
         csum_next = csum_reg ^ byte_mux;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         ch_reg       <= '0;
         idx_reg      <= '0;
         len_err_reg  <= 1'b0;
         drop_cnt_reg <= '0;
`ifdef FAST_CHECKSUM_EN
         csum_reg     <= 8'h00;
`endif
      end else begin
         state_reg <= state_next;
         ch_reg    <= ch_next;
         idx_reg   <= idx_next;
`ifdef FAST_CHECKSUM_EN
         csum_reg  <= csum_next;
`endif
         if (capture) len_err_reg <= |over_len;
         if (bus.message_en_in && state_reg != IDLE && drop_cnt_reg != 16'hFFFF)
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
   end

   // Packet payload holding registers; only meaningful once captured, so no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < CH_NUM; i++) begin
            len_reg[i] <= clamp_len[i];
            for (int j = 0; j < MSG_BYTES; j++) begin
               msg_reg[i][j] <= raw_msg[i][j];
            end
         end
      end
   end

   assign bus.byte_out       = byte_mux;
   assign bus.byte_valid_out = (state_reg != IDLE);
   assign bus.sof_out        = (state_reg == HEAD);
   assign bus.eof_out        = (state_reg == ETX);
   assign bus.busy_out       = (state_reg != IDLE);
   assign bus.len_err_out    = len_err_reg;
   assign bus.drop_cnt_out   = drop_cnt_reg;

endmodule

// File: tb/tb_fast_frame_serializer.sv
// Scoreboard bench for fast_frame_serializer: a frame-level model queues expected bytes,
// a negedge monitor pops and compares on each handshake and checks stability during stalls.
module tb_fast_frame_serializer;
   localparam int         CH_NUM    = 3;
   localparam int         MSG_BYTES = 33;
   localparam int         LEN_BITS  = 6;
   localparam logic [7:0] HEAD_B    = 8'h02;
   localparam logic [7:0] ETX_B     = 8'h03;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fast_frame_serializer_if #(.CH_NUM(CH_NUM), .MSG_BYTES(MSG_BYTES), .LEN_BITS(LEN_BITS)) bus ();

   fast_frame_serializer #(
      .CH_NUM(CH_NUM), .MSG_BYTES(MSG_BYTES), .LEN_BITS(LEN_BITS),
      .HEAD_BYTE(HEAD_B), .ETX_BYTE(ETX_B)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [7:0] b;
      logic       sof;
      logic       eof;
   } exp_t;

   exp_t       exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         cycle = 0;
   int         ready_mode = 0;
   int         rdy_ph = 0;
   int         frames_done = 0;
   int         frames_target = 0;
   int         sof_cyc = 0;
   int         eof_cyc = 0;
   int         exp_len = 0;
   int         exp_drop = 0;
   logic [7:0] tb_msg [CH_NUM][MSG_BYTES];
   int         tb_len [CH_NUM];

   always @(posedge clk) cycle <= cycle + 1;

   // Downstream ready: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1: begin
            bus.byte_ready_in = (rdy_ph == 0);
            rdy_ph = (rdy_ph + 1) % 3;
         end
         2:       bus.byte_ready_in = 1'($urandom_range(0, 1));
         default: bus.byte_ready_in = 1'b1;
      endcase
   end

   // Monitor
   logic stalled = 1'b0;
   exp_t held;
   exp_t got;
   exp_t want;
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         got = '{b: bus.byte_out, sof: bus.sof_out, eof: bus.eof_out};
         if (stalled) begin
            tests++;
            if (!bus.byte_valid_out || got != held) begin
               fails++;
               $display("FAIL stall_stable: got byte=%02h sof=%0b eof=%0b valid=%0b, required byte=%02h sof=%0b eof=%0b valid=1",
                        got.b, got.sof, got.eof, bus.byte_valid_out, held.b, held.sof, held.eof);
            end
         end
         stalled = 1'b0;
         if (bus.byte_valid_out && bus.byte_ready_in) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_byte: got byte=%02h sof=%0b eof=%0b, required no byte", got.b, got.sof, got.eof);
            end else begin
               want = exp_q.pop_front();
               if (got != want) begin
                  fails++;
                  $display("FAIL stream_byte: got byte=%02h sof=%0b eof=%0b, required byte=%02h sof=%0b eof=%0b",
                           got.b, got.sof, got.eof, want.b, want.sof, want.eof);
               end else begin
                  $display("[TB] byte %02h sof=%0b eof=%0b ok", got.b, got.sof, got.eof);
               end
            end
            if (got.sof) sof_cyc = cycle;
            if (got.eof) begin
               eof_cyc = cycle;
               frames_done++;
            end
         end else if (bus.byte_valid_out) begin
            stalled = 1'b1;
            held    = got;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Build the expected frame from the packet, drive it, strobe once (caller is at posedge+1).
   task automatic send();
      int         l;
      logic [7:0] cs;
      logic       exp_err;
      cs      = 8'h00;
      exp_err = 1'b0;
      exp_len = 2;
      exp_q.push_back('{b: HEAD_B, sof: 1'b1, eof: 1'b0});
      for (int c = 0; c < CH_NUM; c++) begin
         l = tb_len[c];
         if (l > MSG_BYTES) begin
            l       = MSG_BYTES;
            exp_err = 1'b1;
         end
         if (l > 0) begin
            exp_q.push_back('{b: 8'(l), sof: 1'b0, eof: 1'b0});
            cs = cs ^ 8'(l);
            exp_len += 1 + l;
            for (int k = 0; k < l; k++) begin
               exp_q.push_back('{b: tb_msg[c][k], sof: 1'b0, eof: 1'b0});
               cs = cs ^ tb_msg[c][k];
            end
         end
      end
`ifdef FAST_CHECKSUM_EN
      exp_q.push_back('{b: cs, sof: 1'b0, eof: 1'b0});
      exp_len += 1;
`endif
      exp_q.push_back('{b: ETX_B, sof: 1'b0, eof: 1'b1});
      for (int c = 0; c < CH_NUM; c++) begin
         bus.length_fast_in[c*LEN_BITS +: LEN_BITS] = LEN_BITS'(tb_len[c]);
         for (int k = 0; k < MSG_BYTES; k++)
            bus.message_fast_in[c*MSG_BYTES*8 + (MSG_BYTES-1-k)*8 +: 8] = tb_msg[c][k];
      end
      bus.message_en_in = 1'b1;
      @(posedge clk);
      #1;
      bus.message_en_in = 1'b0;
      frames_target++;
      $display("[TB] packet lens %0d,%0d,%0d frame %0d bytes", tb_len[0], tb_len[1], tb_len[2], exp_len);
      check("latency_busy", 32'(bus.busy_out), 1);
      check("latency_sof", 32'(bus.byte_valid_out && bus.sof_out), 1);
      check("len_err", 32'(bus.len_err_out), 32'(exp_err));
   endtask

   // Wait (bounded) for the ETX handshake, then check the idle-after-frame conditions.
   task automatic wait_frame();
      int n = 0;
      while (frames_done < frames_target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("frame_done", 32'(frames_done), 32'(frames_target));
      if (frames_done >= frames_target) begin
         check("busy_after_etx", 32'(bus.busy_out), 0);
         if (ready_mode == 0) check("no_gaps", 32'(eof_cyc - sof_cyc), 32'(exp_len - 1));
         check("drop_cnt", 32'(bus.drop_cnt_out), 32'(exp_drop));
      end
   endtask

   task automatic set_plan_packet();
      for (int c = 0; c < CH_NUM; c++)
         for (int k = 0; k < MSG_BYTES; k++) tb_msg[c][k] = 8'($urandom);
      tb_len[0] = 4; tb_len[1] = 0; tb_len[2] = 2;
      tb_msg[0][0] = 8'h41; tb_msg[0][1] = 8'h4E; tb_msg[0][2] = 8'h4E; tb_msg[0][3] = 8'hFF;
      tb_msg[2][0] = 8'h41; tb_msg[2][1] = 8'h4E;
   endtask

   task automatic rand_bytes();
      for (int c = 0; c < CH_NUM; c++)
         for (int k = 0; k < MSG_BYTES; k++) tb_msg[c][k] = 8'($urandom);
   endtask

   initial begin
      bus.message_en_in   = 1'b0;
      bus.message_fast_in = '0;
      bus.length_fast_in  = '0;
      bus.byte_ready_in   = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_byte", 32'(bus.byte_out), 0);
      check("rst_valid", 32'(bus.byte_valid_out), 0);
      check("rst_sof", 32'(bus.sof_out), 0);
      check("rst_eof", 32'(bus.eof_out), 0);
      check("rst_busy", 32'(bus.busy_out), 0);
      check("rst_len_err", 32'(bus.len_err_out), 0);
      check("rst_drop", 32'(bus.drop_cnt_out), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reference packet, ready high then stalling 1,0,0
      ready_mode = 0;
      set_plan_packet();
      send();
      wait_frame();
      ready_mode = 1;
      send();
      wait_frame();

      // All channels empty
      ready_mode = 0;
      tb_len[0] = 0; tb_len[1] = 0; tb_len[2] = 0;
      send();
      wait_frame();

      // Over-length channel clamps and flags; next in-range packet clears the flag
      rand_bytes();
      tb_len[0] = 3; tb_len[1] = 40; tb_len[2] = 1;
      send();
      wait_frame();
      tb_len[0] = 1; tb_len[1] = 1; tb_len[2] = 1;
      send();
      wait_frame();

      // Strobes while busy are dropped; a strobe right after ETX is accepted
      rand_bytes();
      tb_len[0] = 10; tb_len[1] = 10; tb_len[2] = 10;
      send();
      repeat (3) begin
         bus.message_en_in = 1'b1;
         @(posedge clk);
         #1;
         bus.message_en_in = 1'b0;
         exp_drop++;
      end
      check("drop_three", 32'(bus.drop_cnt_out), 32'(exp_drop));
      wait_frame();
      rand_bytes();
      tb_len[0] = 2; tb_len[1] = 0; tb_len[2] = 5;
      send();
      wait_frame();

      // Reset in the middle of BODY aborts the frame
      rand_bytes();
      tb_len[0] = 10; tb_len[1] = 5; tb_len[2] = 5;
      send();
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_byte", 32'(bus.byte_out), 0);
      check("abort_valid", 32'(bus.byte_valid_out), 0);
      check("abort_sof", 32'(bus.sof_out), 0);
      check("abort_eof", 32'(bus.eof_out), 0);
      check("abort_busy", 32'(bus.busy_out), 0);
      check("abort_drop", 32'(bus.drop_cnt_out), 0);
      rst = 1'b0;
      exp_q.delete();
      exp_drop = 0;
      frames_target--;
      rand_bytes();
      tb_len[0] = 1; tb_len[1] = 2; tb_len[2] = 3;
      send();
      wait_frame();

      // Randomised packets and backpressure
      for (int r = 0; r < 25; r++) begin
         ready_mode = $urandom_range(0, 2);
         rand_bytes();
         for (int c = 0; c < CH_NUM; c++)
            tb_len[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 45));
         send();
         wait_frame();
      end

      check("queue_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
